mem_write_buffer: RTL

Posted write buffer between the 2-way set-associative cache's memory port and main memory. The cache's write-backs are acknowledged as soon as they are queued. Queued writes drain to memory in the background. Cache reads bypass queued writes, or are forwarded from the buffer on an address match. Both buses keep the codebase's rd/wr/ready handshake and bidirectional 8-bit data.

---
 rtl/mem_wb_pkg.sv | 29 ++
 rtl/mem_wb_fifo.sv | 110 +++++++++++
 rtl/mem_write_buffer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_wb_pkg
// Brief    : Shared widths, FSM encodings and entry layout for mem_write_buffer
// Revision : 1.0
// ============================================================================
package mem_wb_pkg;

    localparam int MEM_WB_ADDR_W = 16;
    localparam int MEM_WB_DATA_W = 8;

    // Upstream (cache-facing) FSM
    localparam logic [1:0] U_IDLE    = 2'd0;
    localparam logic [1:0] U_ACK     = 2'd1;
    localparam logic [1:0] U_RD_WAIT = 2'd2;

    // Downstream (memory-facing) FSM
    localparam logic [1:0] D_IDLE    = 2'd0;
    localparam logic [1:0] D_WRITE   = 2'd1;
    localparam logic [1:0] D_READ    = 2'd2;

    typedef struct packed {
        logic                     valid;
        logic [MEM_WB_ADDR_W-1:0] addr;
        logic [MEM_WB_DATA_W-1:0] data;
    } mem_wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_fifo
// Brief    : Write-entry ring buffer with coalesce port and address lookup
// Revision : 1.0
// ============================================================================
module mem_wb_fifo
    import mem_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = MEM_WB_ADDR_W,
    parameter int DATA_W = MEM_WB_DATA_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              cw_en,
    input  logic [PTR_W-1:0]  cw_idx,
    input  logic [DATA_W-1:0] cw_data,
    input  logic [ADDR_W-1:0] match_addr,
    input  logic              head_busy,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              coal_hit,
    output logic [PTR_W-1:0]  coal_idx,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [PTR_W:0]    count
);

    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;

    logic [DEPTH-1:0]  w_match;
    logic              w_coal_hit;
    logic [PTR_W-1:0]  w_coal_idx;
    logic              w_head_hit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign w_match[gi] = r_valid[gi] && (r_addr[gi] == match_addr);
    end

    // A busy head may share its address with one newer entry; the newer one wins.
    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = '0;
        w_head_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i]) begin
                if (head_busy && (PTR_W'(i) == r_head)) begin
                    w_head_hit = 1'b1;
                end else begin
                    w_coal_hit = 1'b1;
                    w_coal_idx = PTR_W'(i);
                end
            end
        end
    end

    assign coal_hit  = w_coal_hit;
    assign coal_idx  = w_coal_idx;
    assign fwd_hit   = w_coal_hit || w_head_hit;
    assign fwd_data  = w_coal_hit ? r_data[w_coal_idx] : r_data[r_head];
    assign head_addr = r_addr[r_head];
    assign head_data = r_data[r_head];
    assign count     = r_count;

    always_ff @(posedge clock) begin
        if (push) begin
            r_addr[r_tail] <= push_addr;
            r_data[r_tail] <= push_data;
        end
        if (cw_en) begin
            r_data[cw_idx] <= cw_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_write_buffer
// Brief    : Posted write buffer with read forwarding between cache and memory
// Revision : 1.0
// ============================================================================
module mem_write_buffer
    import mem_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = MEM_WB_ADDR_W,
    parameter int DATA_W = MEM_WB_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_cache,
    inout  wire  [DATA_W-1:0] data_cache,
    input  logic              rd_cache,
    input  logic              wr_cache,
    output logic              ready_cache,
    output logic [ADDR_W-1:0] addr_mem,
    inout  wire  [DATA_W-1:0] data_mem,
    output logic              rd_mem,
    output logic              wr_mem,
    input  logic              ready_mem,
    output logic              empty
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [1:0]        r_u_state;
    logic [1:0]        r_d_state;
    logic              r_rd_req;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_ack_read;
    logic [ADDR_W-1:0] r_addr_mem;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rd_mem;
    logic              r_wr_mem;

    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic              w_coal_hit;
    logic [PTR_W-1:0]  w_coal_idx;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [PTR_W:0]    w_count;
    logic              w_u_idle;
    logic              w_start_write;
    logic              w_head_busy;
    logic              w_push;
    logic              w_coal_en;
    logic              w_pop;
    logic              w_rd_done;
    logic              w_fwd_take;

    // The head counts as busy on the very edge it is latched into the drain
    // registers, so a same-cycle coalesce cannot slip in behind the latch.
    assign w_start_write = (r_d_state == D_IDLE) && !r_rd_req && (w_count != '0);
    assign w_head_busy   = (r_d_state == D_WRITE) || w_start_write;

    assign w_u_idle   = (r_u_state == U_IDLE);
    assign w_coal_en  = w_u_idle && wr_cache && w_coal_hit;
    assign w_push     = w_u_idle && wr_cache && !w_coal_hit && (w_count < C_DEPTH);
    assign w_fwd_take = w_u_idle && !wr_cache && rd_cache && w_fwd_hit;
    assign w_pop      = (r_d_state == D_WRITE) && ready_mem;
    assign w_rd_done  = (r_d_state == D_READ) && ready_mem;

    mem_wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (w_push),
        .push_addr  (addr_cache),
        .push_data  (data_cache),
        .pop        (w_pop),
        .cw_en      (w_coal_en),
        .cw_idx     (w_coal_idx),
        .cw_data    (data_cache),
        .match_addr (addr_cache),
        .head_busy  (w_head_busy),
        .fwd_hit    (w_fwd_hit),
        .fwd_data   (w_fwd_data),
        .coal_hit   (w_coal_hit),
        .coal_idx   (w_coal_idx),
        .head_addr  (w_head_addr),
        .head_data  (w_head_data),
        .count      (w_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_u_state  <= U_IDLE;
            r_rd_req   <= 1'b0;
            r_rd_addr  <= '0;
            r_ack_read <= 1'b0;
        end else begin
            case (r_u_state)
                U_IDLE: begin
                    if (wr_cache) begin
                        r_ack_read <= 1'b0;
                        if (w_push || w_coal_en) begin
                            r_u_state <= U_ACK;
                        end
                    end else if (rd_cache) begin
                        if (w_fwd_hit) begin
                            r_ack_read <= 1'b1;
                            r_u_state  <= U_ACK;
                        end else begin
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= addr_cache;
                            r_u_state <= U_RD_WAIT;
                        end
                    end
                end
                U_RD_WAIT: begin
                    if (w_rd_done) begin
                        r_rd_req   <= 1'b0;
                        r_ack_read <= 1'b1;
                        r_u_state  <= U_ACK;
                    end
                end
                U_ACK:   r_u_state <= U_IDLE;
                default: r_u_state <= U_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (w_fwd_take) begin
            r_rd_data <= w_fwd_data;
        end else if (w_rd_done) begin
            r_rd_data <= data_mem;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_state  <= D_IDLE;
            r_addr_mem <= '0;
            r_wdata    <= '0;
            r_rd_mem   <= 1'b0;
            r_wr_mem   <= 1'b0;
        end else begin
            case (r_d_state)
                D_IDLE: begin
                    if (r_rd_req) begin
                        r_d_state  <= D_READ;
                        r_rd_mem   <= 1'b1;
                        r_addr_mem <= r_rd_addr;
                    end else if (w_start_write) begin
                        r_d_state  <= D_WRITE;
                        r_wr_mem   <= 1'b1;
                        r_addr_mem <= w_head_addr;
                        r_wdata    <= w_head_data;
                    end
                end
                D_WRITE: begin
                    if (ready_mem) begin
                        r_wr_mem  <= 1'b0;
                        r_d_state <= D_IDLE;
                    end
                end
                D_READ: begin
                    if (ready_mem) begin
                        r_rd_mem  <= 1'b0;
                        r_d_state <= D_IDLE;
                    end
                end
                default: r_d_state <= D_IDLE;
            endcase
        end
    end

    assign ready_cache = (r_u_state == U_ACK);
    assign addr_mem    = r_addr_mem;
    assign rd_mem      = r_rd_mem;
    assign wr_mem      = r_wr_mem;
    assign empty       = (w_count == '0) && (r_d_state != D_WRITE);

    assign data_cache  = (ready_cache && r_ack_read) ? r_rd_data : {DATA_W{1'bz}};
    assign data_mem    = r_wr_mem ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire
